// File: rtl/raybox_pov_pkg.sv
// Shared POV widths, reset defaults and the packed POV bundle.
// Field order inside pov_t matches the SPI bit order (px first).
package raybox_pov_pkg;

    localparam int PXY_W    = 15;
    localparam int VEC_W    = 11;
    localparam int POV_BITS = 2 * PXY_W + 4 * VEC_W;
    localparam int CNT_W    = 7;

    typedef struct packed {
        logic [PXY_W-1:0] px;
        logic [PXY_W-1:0] py;
        logic [VEC_W-1:0] fx;
        logic [VEC_W-1:0] fy;
        logic [VEC_W-1:0] vx;
        logic [VEC_W-1:0] vy;
    } pov_t;

    localparam logic [PXY_W-1:0] DEF_PX = 15'h0300;
    localparam logic [PXY_W-1:0] DEF_PY = 15'h0300;
    localparam logic [VEC_W-1:0] DEF_FX = 11'h000;
    localparam logic [VEC_W-1:0] DEF_FY = 11'h200;
    localparam logic [VEC_W-1:0] DEF_VX = 11'h100;
    localparam logic [VEC_W-1:0] DEF_VY = 11'h000;

    localparam pov_t DEF_POV = '{
        px: DEF_PX, py: DEF_PY,
        fx: DEF_FX, fy: DEF_FY,
        vx: DEF_VX, vy: DEF_VY
    };

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(POV_BITS);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(POV_BITS + 1);

endpackage

// File: rtl/pov_sync_edge.sv
// Two-flop synchroniser plus a history flop for edge detection.
// IDLE sets the value all flops take in reset so no edge appears on release.
module pov_sync_edge #(
    parameter logic IDLE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic hist;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= IDLE;
            s2   <= IDLE;
            hist <= IDLE;
        end else begin
            s1   <= d;
            s2   <= s1;
            hist <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~hist;
    assign fall  = ~s2 & hist;

endmodule

// File: rtl/pov_spi_rx.sv
// SPI receiver for the player POV with a staging buffer committed on i_load.
// Optional POV_INC_EN: per-frame px/py auto-increment when no frame is pending.
module pov_spi_rx
    import raybox_pov_pkg::*;
#(
    parameter int INC_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sclk,
    input  logic             i_mosi,
    input  logic             i_ss_n,
    input  logic             i_load,
    input  logic             i_inc_px,
    input  logic             i_inc_py,
    output logic [PXY_W-1:0] o_px,
    output logic [PXY_W-1:0] o_py,
    output logic [VEC_W-1:0] o_fx,
    output logic [VEC_W-1:0] o_fy,
    output logic [VEC_W-1:0] o_vx,
    output logic [VEC_W-1:0] o_vy,
    output logic             o_updated,
    output logic             o_busy,
    output logic             o_err
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic ss_lvl, ss_rise, ss_fall;

    pov_sync_edge #(.IDLE(1'b0)) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (i_sclk),
        .level (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    pov_sync_edge #(.IDLE(1'b0)) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (i_mosi),
        .level (mosi_lvl),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    pov_sync_edge #(.IDLE(1'b1)) u_sync_ss (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (i_ss_n),
        .level (ss_lvl),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    logic [CNT_W-1:0]    cnt;
    logic [POV_BITS-1:0] sr;
    pov_t                staging;
    pov_t                live;
    logic                pending;
    logic                updated;
    logic                err;
    logic                shift_en;
    logic                frame_ok;
    logic                frame_bad;
    logic                commit;

    assign shift_en  = sclk_rise & ~ss_lvl;
    assign frame_ok  = ss_rise & (cnt == CNT_FULL);
    assign frame_bad = ss_rise & (cnt != CNT_FULL);
    assign commit    = i_load & pending;

`ifdef POV_INC_EN
    logic inc_any;
    assign inc_any = i_load & ~pending & (i_inc_px | i_inc_py);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            sr      <= '0;
            staging <= DEF_POV;
            live    <= DEF_POV;
            pending <= 1'b0;
            updated <= 1'b0;
            err     <= 1'b0;
        end else begin
            updated <= 1'b0;
            err     <= frame_bad;
            if (ss_fall) begin
                cnt <= '0;
                sr  <= '0;
            end else if (shift_en) begin
                // Bits past a full frame only bump the count to the too-long marker.
                if (cnt < CNT_FULL)
                    sr <= {sr[POV_BITS-2:0], mosi_lvl};
                if (cnt < CNT_OVER)
                    cnt <= cnt + CNT_W'(1);
            end
            if (frame_ok)
                staging <= pov_t'(sr);
            if (commit) begin
                live    <= staging;
                updated <= 1'b1;
            end
`ifdef POV_INC_EN
            else if (inc_any) begin
                if (i_inc_px)
                    live.px <= live.px + PXY_W'(INC_STEP);
                if (i_inc_py)
                    live.py <= live.py + PXY_W'(INC_STEP);
                updated <= 1'b1;
            end
`endif
            pending <= frame_ok | (pending & ~i_load);
        end
    end

    assign o_px      = live.px;
    assign o_py      = live.py;
    assign o_fx      = live.fx;
    assign o_fy      = live.fy;
    assign o_vx      = live.vx;
    assign o_vy      = live.vy;
    assign o_updated = updated;
    assign o_busy    = ~ss_lvl;
    assign o_err     = err;

    logic unused_ok;
`ifdef POV_INC_EN
    assign unused_ok = &{1'b0, sclk_lvl, sclk_fall, mosi_rise, mosi_fall};
`else
    assign unused_ok = &{1'b0, sclk_lvl, sclk_fall, mosi_rise, mosi_fall,
                         i_inc_px, i_inc_py};
`endif

endmodule

// File: tb/tb_pov_spi_rx.sv
// Directed bench for pov_spi_rx with a frame-level model of live/staging.
// Build with POV_INC_EN defined to cover the auto-increment path.
module tb_pov_spi_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_sclk, i_mosi, i_ss_n, i_load, i_inc_px, i_inc_py;
    logic [14:0] o_px, o_py;
    logic [10:0] o_fx, o_fy, o_vx, o_vy;
    logic        o_updated, o_busy, o_err;

    pov_spi_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_sclk    (i_sclk),
        .i_mosi    (i_mosi),
        .i_ss_n    (i_ss_n),
        .i_load    (i_load),
        .i_inc_px  (i_inc_px),
        .i_inc_py  (i_inc_py),
        .o_px      (o_px),
        .o_py      (o_py),
        .o_fx      (o_fx),
        .o_fy      (o_fy),
        .o_vx      (o_vx),
        .o_vy      (o_vy),
        .o_updated (o_updated),
        .o_busy    (o_busy),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    localparam logic [73:0] DEFS =
        {15'h0300, 15'h0300, 11'h000, 11'h200, 11'h100, 11'h000};

    int          checks = 0;
    int          errors = 0;
    int          err_seen = 0;
    logic        chk_en = 1'b0;
    logic [73:0] exp_live;
    logic [73:0] exp_stage;
    logic        exp_pend;
    logic        exp_upd;

    function automatic logic [74:0] mk(input logic [14:0] px, input logic [14:0] py,
                                       input logic [10:0] fx, input logic [10:0] fy,
                                       input logic [10:0] vx, input logic [10:0] vy);
        return {px, py, fx, fy, vx, vy, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("live", {o_px, o_py, o_fx, o_fy, o_vx, o_vy}, exp_live);
            chk("updated", 74'(o_updated), 74'(exp_upd));
            if (o_err === 1'b1)
                err_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends n bits MSB first from v[74]; close=0 leaves ss_n asserted.
    task automatic spi_send(input logic [74:0] v, input int n, input logic close);
        int e0;
        e0 = err_seen;
        i_ss_n = 1'b0;
        tick(4);
        for (int i = 0; i < n; i++) begin
            i_mosi = v[74-i];
            tick(4);
            i_sclk = 1'b1;
            tick(4);
            i_sclk = 1'b0;
        end
        if (close) begin
            tick(4);
            chk("busy_hi", 74'(o_busy), 74'(1));
            i_ss_n = 1'b1;
            tick(6);
            chk("busy_lo", 74'(o_busy), 74'(0));
            chk("err_pulses", 74'(err_seen - e0), (n == 74) ? 74'(0) : 74'(1));
            if (n == 74) begin
                exp_stage = v[74:1];
                exp_pend  = 1'b1;
            end
        end
    endtask

    task automatic do_load();
        i_load = 1'b1;
        tick(1);
        if (exp_pend) begin
            exp_live = exp_stage;
            exp_pend = 1'b0;
            exp_upd  = 1'b1;
        end
`ifdef POV_INC_EN
        else if (i_inc_px || i_inc_py) begin
            if (i_inc_px) exp_live[73:59] = exp_live[73:59] + 15'd1;
            if (i_inc_py) exp_live[58:44] = exp_live[58:44] + 15'd1;
            exp_upd = 1'b1;
        end
`endif
        i_load = 1'b0;
        tick(1);
        exp_upd = 1'b0;
        tick(2);
    endtask

    logic [74:0] fa, fb, fc, fd, f7;

    initial begin
        rst_n = 1'b0;
        {i_sclk, i_mosi, i_load, i_inc_px, i_inc_py} = '0;
        i_ss_n    = 1'b1;
        exp_live  = DEFS;
        exp_stage = '0;
        exp_pend  = 1'b0;
        exp_upd   = 1'b0;
        fa = mk(15'h1234, 15'h0456, 11'h7FF, 11'h001, 11'h155, 11'h2AA);
        fb = mk(15'h0ABC, 15'h7001, 11'h123, 11'h456, 11'h789, 11'h0F0);
        fc = mk(15'h5555, 15'h2AAA, 11'h400, 11'h3FF, 11'h001, 11'h7FE);
        fd = mk(15'h0042, 15'h0024, 11'h011, 11'h022, 11'h033, 11'h044);
        f7 = mk(15'h7FFF, 15'h0010, 11'h200, 11'h000, 11'h000, 11'h100);
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk_en = 1'b1;
        chk("rst_live", {o_px, o_py, o_fx, o_fy, o_vx, o_vy}, DEFS);
        chk("rst_flags", {71'd0, o_updated, o_busy, o_err}, 74'd0);

        // 1: loads with nothing pending
        do_load();
        do_load();
        do_load();
        chk("t1_defaults", {o_px, o_py, o_fx, o_fy, o_vx, o_vy}, DEFS);

        // 2: good frame held until load
        spi_send(fa, 74, 1'b1);
        chk("t2_noload", {o_px, o_py, o_fx, o_fy, o_vx, o_vy}, DEFS);
        do_load();
        chk("t2_px", 74'(o_px), 74'(15'h1234));
        chk("t2_vy", 74'(o_vy), 74'(11'h2AA));
        chk("t2_all", {o_px, o_py, o_fx, o_fy, o_vx, o_vy},
            {15'h1234, 15'h0456, 11'h7FF, 11'h001, 11'h155, 11'h2AA});

        // 3: short and long frames do not clobber a pending good frame
        spi_send(fc, 74, 1'b1);
        spi_send(fb, 73, 1'b1);
        spi_send(fb, 75, 1'b1);
        chk("t3_nochange", 74'(o_px), 74'(15'h1234));
        do_load();
        chk("t3_px", 74'(o_px), 74'(15'h5555));

        // 4: last good frame wins; bad frame after good one ignored
        spi_send(fa, 74, 1'b1);
        spi_send(fb, 74, 1'b1);
        do_load();
        chk("t4_b", 74'(o_py), 74'(15'h7001));
        spi_send(fd, 74, 1'b1);
        spi_send(fa, 60, 1'b1);
        do_load();
        chk("t4_d", 74'(o_fx), 74'(11'h011));

        // 5: reset mid-transfer
        spi_send(fa, 40, 1'b0);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        i_ss_n = 1'b1;
        i_sclk = 1'b0;
        tick(3);
        exp_live = DEFS;
        exp_pend = 1'b0;
        rst_n = 1'b1;
        tick(1);
        chk_en = 1'b1;
        chk("t5_defaults", {o_px, o_py, o_fx, o_fy, o_vx, o_vy}, DEFS);
        spi_send(fc, 74, 1'b1);
        chk("t5_preload", 74'(o_fy), 74'(11'h200));
        do_load();
        chk("t5_px", 74'(o_px), 74'(15'h5555));

        // 6: increment inputs
        spi_send(f7, 74, 1'b1);
        do_load();
        chk("t6_base", 74'(o_px), 74'(15'h7FFF));
        i_inc_px = 1'b1;
        do_load();
`ifdef POV_INC_EN
        chk("t6_wrap", 74'(o_px), 74'(15'h0000));
`else
        chk("t6_wrap", 74'(o_px), 74'(15'h7FFF));
`endif
        do_load();
`ifdef POV_INC_EN
        chk("t6_inc", 74'(o_px), 74'(15'h0001));
`else
        chk("t6_inc", 74'(o_px), 74'(15'h7FFF));
`endif
        spi_send(fd, 74, 1'b1);
        do_load();
        chk("t6_spi_wins", 74'(o_px), 74'(15'h0042));
        i_inc_px = 1'b0;
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
